// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, opcode/funct values and decoded-op record
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SLL  = 4'b0100,
      ALU_NOR  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SRLV = 4'b1000,
      ALU_SLLV = 4'b1001,
      ALU_SRAV = 4'b1010,
      ALU_SRL  = 4'b1100,
      ALU_SRA  = 4'b1110
   } alu_ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;

   // wide enough for any supported thread count; upper bits stay zero
   localparam int TID_MAX_W = 8;

   typedef struct packed {
      alu_ctrl_t              alu_ctrl;
      logic [4:0]             shamt;
      logic                   src_imm;
      logic                   zext;
      logic                   illegal;
      logic [TID_MAX_W-1:0]   tid;
   } dec_op_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// alu_op_decode_comb: instruction word to ALU control fields (tid left 0); ALU_VSHIFT_EN enables SLLV/SRLV/SRAV
module alu_op_decode_comb
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output dec_op_t     dec
);

   logic w_unused_fields;
   assign w_unused_fields = ^instr[25:11];

   // decode opcode, then funct for R-type; anything unknown is flagged illegal with zeroed fields
   always_comb begin
      dec = '0;
      case (instr[31:26])
         OP_RTYPE:
            case (instr[5:0])
               F_ADD, F_ADDU: dec.alu_ctrl = ALU_ADD;
               F_SUB, F_SUBU: dec.alu_ctrl = ALU_SUB;
               F_AND:         dec.alu_ctrl = ALU_AND;
               F_OR:          dec.alu_ctrl = ALU_OR;
               F_NOR:         dec.alu_ctrl = ALU_NOR;
               F_SLT:         dec.alu_ctrl = ALU_SLT;
               F_SLL: begin
                  dec.alu_ctrl = ALU_SLL;
                  dec.shamt    = instr[10:6];
               end
               F_SRL: begin
                  dec.alu_ctrl = ALU_SRL;
                  dec.shamt    = instr[10:6];
               end
               F_SRA: begin
                  dec.alu_ctrl = ALU_SRA;
                  dec.shamt    = instr[10:6];
               end
`ifdef ALU_VSHIFT_EN
               F_SLLV:        dec.alu_ctrl = ALU_SLLV;
               F_SRLV:        dec.alu_ctrl = ALU_SRLV;
               F_SRAV:        dec.alu_ctrl = ALU_SRAV;
`endif
               default:       dec.illegal  = 1'b1;
            endcase
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            dec.alu_ctrl = ALU_ADD;
            dec.src_imm  = 1'b1;
         end
         OP_SLTI: begin
            dec.alu_ctrl = ALU_SLT;
            dec.src_imm  = 1'b1;
         end
         OP_ANDI: begin
            dec.alu_ctrl = ALU_AND;
            dec.src_imm  = 1'b1;
            dec.zext     = 1'b1;
         end
         OP_ORI: begin
            dec.alu_ctrl = ALU_OR;
            dec.src_imm  = 1'b1;
            dec.zext     = 1'b1;
         end
         OP_BEQ, OP_BNE: dec.alu_ctrl = ALU_SUB;
         default:        dec.illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered ALU op decode with 2-entry skid buffer and per-thread flush; ALU_VSHIFT_EN enables variable shifts
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int NTHREADS = 4,
   localparam int TID_W = $clog2(NTHREADS)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TID_W-1:0] in_tid,
   input  logic             flush_valid,
   input  logic [TID_W-1:0] flush_tid,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_alu_ctrl,
   output logic [4:0]       out_shamt,
   output logic             out_src_imm,
   output logic             out_zext,
   output logic             out_illegal,
   output logic [TID_W-1:0] out_tid
);

   dec_op_t w_dec, w_new, r_out, r_sk;
   logic    r_ov, r_sv, w_fo, w_fs, w_ov, w_sv, w_acc, w_free;

   alu_op_decode_comb u_dec (
      .instr (in_instr),
      .dec   (w_dec)
   );

   // stamp the incoming thread id onto the decoded fields
   always_comb begin
      w_new     = w_dec;
      w_new.tid = w_dec.tid | TID_MAX_W'(in_tid);
   end

   assign w_fo   = flush_valid & r_ov & (r_out.tid == TID_MAX_W'(flush_tid));
   assign w_fs   = flush_valid & r_sv & (r_sk.tid == TID_MAX_W'(flush_tid));
   assign w_ov   = r_ov & ~w_fo;
   assign w_sv   = r_sv & ~w_fs;
   assign w_acc  = in_valid & in_ready & ~(flush_valid & (in_tid == flush_tid));
   assign w_free = ~w_ov | out_ready;

   // output slot refills from skid first (FIFO order), else from the new word; held slot parks the new word in skid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= '0;
         r_sk  <= '0;
         r_ov  <= 1'b0;
         r_sv  <= 1'b0;
      end else if (w_free) begin
         r_out <= w_sv ? r_sk : w_new;
         r_ov  <= w_sv | w_acc;
         r_sv  <= 1'b0;
      end else begin
         if (!w_sv) r_sk <= w_new;
         r_sv <= w_sv | w_acc;
      end
   end

   assign in_ready     = ~r_sv;
   assign out_valid    = r_ov;
   assign out_alu_ctrl = r_out.alu_ctrl;
   assign out_shamt    = r_out.shamt;
   assign out_src_imm  = r_out.src_imm;
   assign out_zext     = r_out.zext;
   assign out_illegal  = r_out.illegal;
   assign out_tid      = r_out.tid[TID_W-1:0];

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Decode stage that produces the ALU's operation code, shift amount and operand-select for each issued instruction word.
- Sits between per-thread fetch/issue and the ALU in the fine-grained multithreaded core; it is the producer end of the ALUControl/shamt interface.
- Registered output with valid/ready handshake, a 2-entry skid buffer and per-thread flush.

Parameters:
NTHREADS, 4, number of hardware threads (power of 2, ≥2)
TID_W, $clog2(NTHREADS), thread-id width (derived, localparam)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  instruction word valid
in_ready  output  1  decoder can accept a word
in_instr  input  32  MIPS instruction word
in_tid  input  TID_W  thread id of in_instr
flush_valid  input  1  squash request
flush_tid  input  TID_W  thread to squash
out_valid  output  1  decoded op valid
out_ready  input  1  ALU stage accepts
out_alu_ctrl  output  4  ALUControl code
out_shamt  output  5  instr[10:6] for R-type shifts, else 0
out_src_imm  output  1  B operand = sign/zero-extended immediate
out_zext  output  1  immediate is zero-extended (andi/ori)
out_illegal  output  1  unsupported opcode/funct
out_tid  output  TID_W  thread id

Behaviour:
- Reset: out_valid=0, in_ready=1, skid empty; all data outputs 0.
- Codes: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, NOR 0101, SLL 0100, SRL 1100, SRA 1110, SRLV 1000, SLLV 1001, SRAV 1010.
- R-type (op 0x00), by funct:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB
  - 0x24 → AND; 0x25 → OR; 0x27 → NOR; 0x2A → SLT
  - 0x00 → SLL; 0x02 → SRL; 0x03 → SRA
  - 0x04 → SLLV; 0x06 → SRLV; 0x07 → SRAV
- I-type, by op:
  - 0x08/0x09/0x23/0x2B → ADD, src_imm=1
  - 0x0A → SLT, src_imm=1
  - 0x0C → AND, src_imm=1, zext=1
  - 0x0D → OR, src_imm=1, zext=1
  - 0x04/0x05 → SUB, src_imm=0
- Any other op/funct → illegal=1, alu_ctrl=0000, src_imm=0, shamt=0; the word still flows so the downstream stage can raise the exception.
- Latency: 1 cycle, from accepted input to out_valid.
- Handshakes:
  - Input transfer when in_valid&in_ready.
  - Output transfer when out_valid&out_ready.
  - in_ready = ~skid_full, registered; it does not depend combinationally on out_ready.
- Skid buffer:
  - If the output register is held (out_valid&~out_ready) when an input is accepted, the input goes to the skid entry.
  - On the next output transfer, skid moves to the output register.
  - Order per thread and globally is FIFO; maximum occupancy is 2.
  - Simultaneous accept and output transfer with skid empty: new word loads the output register directly.
- Flush (single cycle):
  - Invalidates the output register and/or skid entry whose tid==flush_tid.
  - Also drops a same-cycle accepted input with that tid.
  - If only the output entry is flushed and skid holds another thread, skid advances to the output register in that cycle.
  - Flush has priority over out_ready for a matching output entry: no transfer is counted.
- Reset mid-operation empties both entries with no output transfer.
- Stable outputs: data is stable while out_valid&~out_ready, unless that entry is flushed.

Optional Feature:
- ALU_VSHIFT_EN defined: funct 0x04/0x06/0x07 decode to SLLV/SRLV/SRAV.
- Undefined: those functs are illegal (alu_ctrl=0000, illegal=1).

Decomposition:
- Package alu_pkg:
  - typedef enum logic[3:0] alu_ctrl_t with the twelve codes above.
  - Opcode and funct localparams.
  - Struct dec_op_t {alu_ctrl, shamt, src_imm, zext, illegal, tid}.
- Sub-module alu_op_decode_comb: purely combinational instruction → dec_op_t (minus tid).
- Top alu_op_decoder: skid buffer, handshake and flush.

Test Plan:
- Reset then in_instr=0x012A4020 (add) tid=1, out_ready=1 → next cycle out_valid=1, alu_ctrl=0010, tid=1, illegal=0.
- sra instr 0x000A40C3, then ori 0x3508FFFF → alu_ctrl=1110 shamt=3, then alu_ctrl=0001 src_imm=1 zext=1.
- out_ready=0 while feeding three words tid 0,1,2 → third cycle in_ready=0; raise out_ready → outputs emerge in order 0,1,2.
- Output holds tid=2 and skid holds tid=3, flush_tid=2 → tid=2 never transfers; tid=3 appears next cycle.
- srlv 0x01494006 → alu_ctrl=1000 with ALU_VSHIFT_EN; illegal=1, alu_ctrl=0000 without it.
- Opcode 0x3F, or reset asserted with both entries full → illegal=1 for the opcode; after reset, out_valid=0 and in_ready=1.
